// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// pipe_hazard_ctrl
//
// Stall and flush sequencer for a 5-stage pipeline
// (IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers).
//
// The block handles three hazard sources, in this priority order:
//   1. Multi-cycle data-memory access in MEM. A two-state FSM (IDLE/WAIT)
//      and a latency down-counter freeze the whole pipeline. MEM/WB gets a
//      bubble so the instruction in MEM writes back only once.
//   2. Taken branch resolved in EX. IF/ID and ID/EX are flushed and the PC
//      is redirected.
//   3. Load-use hazard between a load in EX and its consumer in ID. The PC
//      and IF/ID are held and a bubble is inserted into ID/EX.
//
// All control outputs are combinational functions of state, counter and
// inputs, so they take effect in the same cycle. While rst_i is high every
// output takes its default (free-running) value.
//
// Parameters:
//   MEM_LAT : data-memory latency in cycles (1..15). 1 = never stalls.
//   CNT_W   : latency counter width; 2**CNT_W must exceed MEM_LAT.
//
// Optional build macro:
//   PIPE_HAZARD_CTRL_PERF_EN : when defined, builds the 32-bit stall_cnt and
//                              flush_cnt performance counters. When it is
//                              undefined, both outputs are tied to zero and
//                              no counter flops are built.
//
// Ports:
//   clk_i          in   clock, rising edge
//   rst_i          in   asynchronous active-high reset
//   ID_Rs, ID_Rt   in   source register fields of the instruction in ID
//   EX_MemRead     in   instruction in EX is a load
//   EX_Rt          in   destination register of the load in EX
//   EX_BranchTaken in   branch in EX resolved taken
//   MEM_MemRead    in   instruction in MEM reads data memory
//   MEM_MemWrite   in   instruction in MEM writes data memory
//   PC_Write       out  PC updates this cycle
//   IF_ID_Write    out  IF/ID loads
//   IF_ID_Flush    out  IF/ID loads a NOP
//   ID_EX_Write    out  ID/EX loads
//   ID_EX_Flush    out  ID/EX loads zeroed control
//   EX_MEM_Write   out  EX/MEM loads
//   MEM_WB_Bubble  out  MEM/WB loads RegWrite=0, MemtoReg=0
//   mem_busy       out  FSM is in WAIT
//   stall_cnt      out  stall-cycle performance counter
//   flush_cnt      out  branch-flush performance counter
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_Rt,
    input  logic        EX_BranchTaken,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    output logic        PC_Write,
    output logic        IF_ID_Write,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Write,
    output logic        ID_EX_Flush,
    output logic        EX_MEM_Write,
    output logic        MEM_WB_Bubble,
    output logic        mem_busy,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // The cycle an access enters MEM is its first latency cycle, so WAIT
    // only needs to cover the remaining MEM_LAT-1 cycles.
    localparam logic [CNT_W-1:0] LP_CNT_LOAD = CNT_W'(MEM_LAT - 1);
    localparam bit               LP_MULTI    = (MEM_LAT > 1);
    localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    logic w_mem_req;
    logic w_mem_stall;
    logic w_load_use;
    logic w_load_use_stall;   // load-use that actually wins priority
    logic w_branch_flush;     // branch that actually wins priority

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    assign w_mem_req = MEM_MemRead | MEM_MemWrite;

    // The last WAIT cycle (cnt==1) does not stall. The access completes on
    // that edge, and the instruction leaves MEM.
    assign w_mem_stall = ((r_state == ST_IDLE) && w_mem_req && LP_MULTI) ||
                         ((r_state == ST_WAIT) && (r_cnt > LP_CNT_ONE));

    // $0 is hard-wired to zero, so a load targeting it can never feed data.
    assign w_load_use = EX_MemRead && (EX_Rt != 5'd0) &&
                        ((EX_Rt == ID_Rs) || (EX_Rt == ID_Rt));

    assign w_branch_flush   = !rst_i && !w_mem_stall && EX_BranchTaken;
    assign w_load_use_stall = !rst_i && !w_mem_stall && !EX_BranchTaken &&
                              w_load_use;

    // ------------------------------------------------------------------
    // Memory-wait FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_mem_req && LP_MULTI) begin
                    w_state_next = ST_WAIT;
                    w_cnt_next   = LP_CNT_LOAD;
                end
            end
            ST_WAIT: begin
                if (r_cnt > LP_CNT_ONE) begin
                    w_cnt_next = r_cnt - LP_CNT_ONE;
                end else begin
                    // Release cycle. A following memory instruction reaches
                    // MEM at this edge and re-arms WAIT from IDLE on the
                    // next cycle with no extra gap.
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Memory-wait FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline control outputs
    // ------------------------------------------------------------------
    always_comb begin
        PC_Write      = 1'b1;
        IF_ID_Write   = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EX_Write   = 1'b1;
        ID_EX_Flush   = 1'b0;
        EX_MEM_Write  = 1'b1;
        MEM_WB_Bubble = 1'b0;

        // During reset the state register may still be settling, and the
        // inputs may carry garbage. Gating here keeps every output at its
        // default value.
        if (!rst_i) begin
            if (w_mem_stall) begin
                // Whole pipeline frozen. Branch and load-use handling waits
                // until their stages can move again.
                PC_Write      = 1'b0;
                IF_ID_Write   = 1'b0;
                ID_EX_Write   = 1'b0;
                EX_MEM_Write  = 1'b0;
                MEM_WB_Bubble = 1'b1;
            end else if (EX_BranchTaken) begin
                // The ID instruction is squashed, so load-use is irrelevant.
                IF_ID_Flush = 1'b1;
                ID_EX_Flush = 1'b1;
                PC_Write    = 1'b1;
            end else if (w_load_use) begin
                PC_Write    = 1'b0;
                IF_ID_Write = 1'b0;
                ID_EX_Flush = 1'b1;
            end
        end
    end

    assign mem_busy = !rst_i && (r_state == ST_WAIT);

    // ------------------------------------------------------------------
    // Optional performance counters
    // ------------------------------------------------------------------
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;
    logic        w_stall_evt;

    assign w_stall_evt = (!rst_i && w_mem_stall) || w_load_use_stall;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (w_stall_evt) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_branch_flush) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    // The priority terms are only consumed by the counters.
    logic w_unused_evt;
    assign w_unused_evt = w_load_use_stall ^ w_branch_flush;

    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule
